// File: rtl/preg_free_list_if.sv
// rtl/preg_free_list_if.sv - Rename/commit handshake bundle for the physical register free list
//
// Purpose : groups the allocate (rename) and free (commit) signals of the
//           physical register free list into one interface.
// Ports   : alloc_en   rename consumes alloc_preg this cycle
//           alloc_rdy  a free preg is available
//           alloc_preg preg at the head of the free list
//           free_en    commit returns a previous preg this cycle
//           free_preg  preg being returned
//           free_count number of free pregs held
//           err        sticky protocol-violation flag
// Modports: master = rename/commit side, slave = free list.

interface preg_free_list_if #(
   parameter int P_NUM_PHYS_REGS = 36,
   parameter int P_NUM_ARCH_REGS = 32
);
   localparam int PW    = $clog2(P_NUM_PHYS_REGS);
   localparam int DEPTH = P_NUM_PHYS_REGS - P_NUM_ARCH_REGS;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          alloc_en;
   logic          alloc_rdy;
   logic [PW-1:0] alloc_preg;
   logic          free_en;
   logic [PW-1:0] free_preg;
   logic [CW-1:0] free_count;
   logic          err;

   modport master (
      output alloc_en,
      input  alloc_rdy,
      input  alloc_preg,
      output free_en,
      output free_preg,
      input  free_count,
      input  err
   );

   modport slave (
      input  alloc_en,
      output alloc_rdy,
      output alloc_preg,
      input  free_en,
      input  free_preg,
      output free_count,
      output err
   );
endinterface

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - Circular-FIFO free list of physical registers for register renaming
//
// Purpose : holds the physical registers not currently mapped to an
//           architectural register. Rename pops from the head, commit pushes
//           released pregs at the tail. Illegal frees are dropped and raise a
//           sticky err.
// Ports   : clk  clock, all state updates on posedge
//           rst  synchronous active-high reset
//           bus  preg_free_list_if.slave (alloc_en/alloc_rdy/alloc_preg,
//                free_en/free_preg, free_count, err)
// Options : PREG_FREE_LIST_CHECK_EN adds a per-preg in_list vector so a
//           double free is rejected and flagged in err.

module preg_free_list #(
   parameter int P_NUM_PHYS_REGS = 36,
   parameter int P_NUM_ARCH_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   preg_free_list_if.slave bus
);
   localparam int PW    = $clog2(P_NUM_PHYS_REGS);
   localparam int DEPTH = P_NUM_PHYS_REGS - P_NUM_ARCH_REGS;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One extra bit so the range check also works when P_NUM_PHYS_REGS is a power of two.
   localparam logic [PW:0]   PHYS_LIM = (PW+1)'(P_NUM_PHYS_REGS);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   logic [PW-1:0] entry_q [DEPTH];
   logic [AW-1:0] head_q;
   logic [AW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic          err_q;

   logic          alloc_fire;
   logic          range_ok;
   logic          overflow;
   logic          dbl_free;
   logic          free_fire;
   logic          free_bad;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Outputs depend on registered state only, so rename can look at
   // alloc_preg before deciding whether to assert alloc_en.
   assign bus.alloc_rdy  = (count_q != '0);
   assign bus.alloc_preg = entry_q[head_q];
   assign bus.free_count = count_q;
   assign bus.err        = err_q;

   always_comb begin
      alloc_fire = bus.alloc_en && (count_q != '0);
      // preg 0 is the hardwired x0 mapping and is never returned to the pool.
      range_ok   = (bus.free_preg != '0) && ({1'b0, bus.free_preg} < PHYS_LIM);
      // A full list can still take a free if a slot opens the same cycle.
      overflow   = (count_q == FULL_CNT) && !alloc_fire;
   end

`ifdef PREG_FREE_LIST_CHECK_EN
   logic [P_NUM_PHYS_REGS-1:0] in_list_q;
   logic [P_NUM_PHYS_REGS-1:0] in_list_d;

   function automatic logic [P_NUM_PHYS_REGS-1:0] in_list_init();
      logic [P_NUM_PHYS_REGS-1:0] r;
      for (int i = 0; i < P_NUM_PHYS_REGS; i++) begin
         r[i] = (i >= P_NUM_ARCH_REGS);
      end
      return r;
   endfunction

   // Only consulted when the index is known to be in range.
   assign dbl_free = range_ok && in_list_q[bus.free_preg];

   always_comb begin
      in_list_d = in_list_q;
      if (alloc_fire) begin
         in_list_d[entry_q[head_q]] = 1'b0;
      end
      if (free_fire) begin
         in_list_d[bus.free_preg] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_list_q <= in_list_init();
      end else begin
         in_list_q <= in_list_d;
      end
   end
`else
   assign dbl_free = 1'b0;
`endif

   always_comb begin
      free_bad  = bus.free_en && (!range_ok || overflow || dbl_free);
      free_fire = bus.free_en && !free_bad;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= PW'(P_NUM_ARCH_REGS + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= FULL_CNT;
         err_q   <= 1'b0;
      end else begin
         if (alloc_fire) begin
            head_q <= ptr_inc(head_q);
         end
         // Written entry only becomes visible at the head next cycle: no bypass.
         if (free_fire) begin
            entry_q[tail_q] <= bus.free_preg;
            tail_q          <= ptr_inc(tail_q);
         end
         case ({alloc_fire, free_fire})
            2'b10:   count_q <= count_q - 1'b1;
            2'b01:   count_q <= count_q + 1'b1;
            default: count_q <= count_q;
         endcase
         if (free_bad) begin
            err_q <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_preg_free_list.sv
// tb/tb_preg_free_list.sv - Directed table-driven bench for preg_free_list

module tb_preg_free_list;
   localparam int NP = 36;
   localparam int NA = 32;

   typedef struct packed {
      logic       rst;
      logic       alloc_en;
      logic       free_en;
      logic [5:0] free_preg;
      logic       exp_rdy;
      logic [5:0] exp_preg;
      logic [2:0] exp_count;
      logic       exp_err;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t vecs [$];

   preg_free_list_if #(.P_NUM_PHYS_REGS(NP), .P_NUM_ARCH_REGS(NA)) bus ();

   preg_free_list #(.P_NUM_PHYS_REGS(NP), .P_NUM_ARCH_REGS(NA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic ae, input logic fe, input int fp,
                      input logic rdy, input int preg, input int cnt, input logic e);
      vec_t v;
      v.rst       = r;
      v.alloc_en  = ae;
      v.free_en   = fe;
      v.free_preg = 6'(fp);
      v.exp_rdy   = rdy;
      v.exp_preg  = 6'(preg);
      v.exp_count = 3'(cnt);
      v.exp_err   = e;
      vecs.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input logic rdy, input logic [5:0] preg,
                                input logic [2:0] cnt, input logic e);
      checks++;
      if (bus.alloc_rdy !== rdy) begin
         failures++;
         $display("FAIL %s.alloc_rdy got=%0b exp=%0b", tag, bus.alloc_rdy, rdy);
      end
      checks++;
      if (bus.alloc_preg !== preg) begin
         failures++;
         $display("FAIL %s.alloc_preg got=%0d exp=%0d", tag, bus.alloc_preg, preg);
      end
      checks++;
      if (bus.free_count !== cnt) begin
         failures++;
         $display("FAIL %s.free_count got=%0d exp=%0d", tag, bus.free_count, cnt);
      end
      checks++;
      if (bus.err !== e) begin
         failures++;
         $display("FAIL %s.err got=%0b exp=%0b", tag, bus.err, e);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Each row: inputs applied for one clock, outputs expected after that edge.
      //   rst ae fe preg   rdy preg cnt err
      // drain the list, then one ignored request
      add(0, 1, 0, 0,      1, 33, 3, 0);
      add(0, 1, 0, 0,      1, 34, 2, 0);
      add(0, 1, 0, 0,      1, 35, 1, 0);
      add(0, 1, 0, 0,      0, 32, 0, 0);
      add(0, 1, 0, 0,      0, 32, 0, 0);
      // empty: free 5 with alloc same cycle, alloc must not see 5 yet
      add(0, 1, 1, 5,      1, 5,  1, 0);
      add(0, 1, 0, 0,      0, 33, 0, 0);
      // reset overrides same-cycle alloc/free
      add(1, 1, 1, 7,      1, 32, 4, 0);
      // full list: simultaneous alloc 32 and free 7, then 33,34,35,7
      add(0, 1, 1, 7,      1, 33, 4, 0);
      add(0, 1, 0, 0,      1, 34, 3, 0);
      add(0, 1, 0, 0,      1, 35, 2, 0);
      add(0, 1, 0, 0,      1, 7,  1, 0);
      add(0, 1, 0, 0,      0, 33, 0, 0);
      // overflow: free 9 at full with no alloc, err is sticky
      add(1, 0, 0, 0,      1, 32, 4, 0);
      add(0, 0, 1, 9,      1, 32, 4, 1);
      add(0, 0, 0, 0,      1, 32, 4, 1);
      // free of preg 0
      add(1, 0, 0, 0,      1, 32, 4, 0);
      add(0, 0, 1, 0,      1, 32, 4, 1);
      // free of out-of-range preg 36
      add(1, 0, 0, 0,      1, 32, 4, 0);
      add(0, 0, 1, 36,     1, 32, 4, 1);
      // alloc 32 then free 33 (still in the list)
      add(1, 0, 0, 0,      1, 32, 4, 0);
      add(0, 1, 0, 0,      1, 33, 3, 0);
`ifdef PREG_FREE_LIST_CHECK_EN
      add(0, 0, 1, 33,     1, 33, 3, 1);
      add(0, 0, 1, 32,     1, 33, 4, 1);
`else
      add(0, 0, 1, 33,     1, 33, 4, 0);
      add(0, 0, 1, 32,     1, 33, 4, 1);
`endif
      // mid-sequence reset restores everything
      add(1, 1, 1, 3,      1, 32, 4, 0);

      rst           = 1'b1;
      bus.alloc_en  = 1'b0;
      bus.free_en   = 1'b0;
      bus.free_preg = '0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset", 1'b1, 6'd32, 3'd4, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst           = vecs[i].rst;
         bus.alloc_en  = vecs[i].alloc_en;
         bus.free_en   = vecs[i].free_en;
         bus.free_preg = vecs[i].free_preg;
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_preg,
                       vecs[i].exp_count, vecs[i].exp_err);
      end

      // Combinational outputs must not follow alloc_en/free_en within a cycle.
      @(negedge clk);
      rst           = 1'b0;
      bus.alloc_en  = 1'b1;
      bus.free_en   = 1'b1;
      bus.free_preg = 6'd9;
      #1;
      check_outputs("comb_only", 1'b1, 6'd32, 3'd4, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("after_comb", 1'b1, 6'd33, 3'd4, 1'b0);
      @(negedge clk);
      bus.alloc_en = 1'b0;
      bus.free_en  = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 Parameter P_NUM_PHYS_REGS, default 36, total physical registers.
REQ-002 Parameter P_NUM_ARCH_REGS, default 32, architectural registers, initially mapped to pregs 0..P_NUM_ARCH_REGS-1.
REQ-003 Derived widths: PW = $clog2(P_NUM_PHYS_REGS); DEPTH = P_NUM_PHYS_REGS-P_NUM_ARCH_REGS; CW = $clog2(DEPTH+1).
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alloc_en  input  1  rename stage consumes alloc_preg this cycle.
REQ-007 alloc_rdy  output  1  a free preg is available.
REQ-008 alloc_preg  output  PW  preg handed out on the next allocation (head of list).
REQ-009 free_en  input  1  commit returns a previous preg this cycle.
REQ-010 free_preg  input  PW  preg being returned.
REQ-011 free_count  output  CW  number of free pregs held.
REQ-012 err  output  1  sticky protocol-violation flag.

Function
REQ-013 Storage is a circular FIFO of DEPTH PW-bit entries with head pointer, tail pointer and occupancy counter.
REQ-014 alloc_rdy = (free_count != 0); alloc_preg = entry[head]; both combinational from state only, with no dependence on alloc_en or free_en.
REQ-015 Allocation fires when alloc_en & alloc_rdy: head advances by one, wrapping from DEPTH-1 to 0.
REQ-016 alloc_en with alloc_rdy=0 is ignored: no state change and no error.
REQ-017 An accepted free writes free_preg to entry[tail]; tail advances, wrapping from DEPTH-1 to 0.
REQ-018 A freed preg is allocatable no earlier than the cycle after free_en; there is no free-to-alloc bypass.
REQ-019 Accepted alloc and accepted free in the same cycle: free_count is unchanged and both pointers advance.
REQ-020 Only alloc accepted: free_count decrements. Only free accepted: free_count increments.
REQ-021 Free with free_preg==0 (x0 mapping) or free_preg>=P_NUM_PHYS_REGS is rejected: no state change, err set.
REQ-022 Overflow is free_en when free_count==DEPTH and no allocation fires that cycle; it is rejected with no state change and err set.
REQ-023 Free when free_count==DEPTH while an allocation fires the same cycle is legal and handled per REQ-019.
REQ-024 err, once set, stays 1 until rst.

Reset
REQ-025 On rst: entry[i] = P_NUM_ARCH_REGS+i for i in 0..DEPTH-1; head=0; tail=0; free_count=DEPTH; err=0.
REQ-026 After reset outputs are alloc_rdy=1, alloc_preg=P_NUM_ARCH_REGS and free_count=DEPTH.
REQ-027 rst asserted mid-operation overrides same-cycle alloc_en and free_en and restores the full REQ-025 state in one cycle.

Configuration
REQ-028 Macro PREG_FREE_LIST_CHECK_EN.
- Defined: a P_NUM_PHYS_REGS-bit in_list vector is added. At reset it is 1 for pregs P_NUM_ARCH_REGS..P_NUM_PHYS_REGS-1. Allocation clears the allocated bit; an accepted free sets the freed bit.
- Defined: a free of a preg whose bit is already 1 (double free) is rejected with no state change and sets err.
- Not defined: in_list logic is absent, double frees are not detected, and err reflects only REQ-021 and REQ-022.

Verification
REQ-029 Reset with defaults -> alloc_rdy=1, alloc_preg=32, free_count=4, err=0.
REQ-030 alloc_en held 5 cycles after reset -> pregs 32,33,34,35 handed out; then alloc_rdy=0, free_count=0; 5th request ignored, err=0.
REQ-031 From empty, free_en with free_preg=5 and alloc_en in the same cycle -> no allocation that cycle; next cycle alloc_preg=5, free_count=1.
REQ-032 At free_count=4: simultaneous alloc (32) and free of 7 -> free_count stays 4; next allocations are 33,34,35,7.
REQ-033 Free of 9 at free_count=4 with no alloc -> err=1, free_count=4. Separately, free of preg 0 -> err=1.
REQ-034 With PREG_FREE_LIST_CHECK_EN: alloc 32, then free 33 -> err=1, free_count=3. After rst mid-sequence -> err=0, free_count=4, alloc_preg=32.
